wb_controller: RTL and testbench

Write-back controller that schedules the register file's single write port between two requesters: the execute stage (ALU results tagged with the 6-bit opcode) and the data-memory load-return path. It decodes the opcode to decide whether a result is written at all, splits 32-bit MUL products into two 16-bit register writes, and arbitrates contested cycles round-robin. It sits between the ALU result selection and the register file, and drives the register-file write port.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_rr_arb.sv | 31 +++
 rtl/wb_controller.sv | 123 ++++++++++++
 tb/tb_wb_controller.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - opcode map, FSM state and write-class decode for the write-back controller.
package wb_pkg;

  localparam logic [5:0] OP_MOV0  = 6'b000000;
  localparam logic [5:0] OP_MOV1  = 6'b000001;
  localparam logic [5:0] OP_LOAD  = 6'b000010;
  localparam logic [5:0] OP_STORE = 6'b000011;
  localparam logic [5:0] OP_ADD   = 6'b000100;
  localparam logic [5:0] OP_SUB   = 6'b000101;
  localparam logic [5:0] OP_AND   = 6'b000110;
  localparam logic [5:0] OP_MUL   = 6'b000111;
  localparam logic [5:0] OP_OR    = 6'b001000;
  localparam logic [5:0] OP_XOR   = 6'b001001;
  localparam logic [5:0] OP_NOT   = 6'b001010;
  localparam logic [5:0] OP_LSH   = 6'b001011;
  localparam logic [5:0] OP_RSH   = 6'b001100;
  localparam logic [5:0] OP_ARSH  = 6'b001101;
  localparam logic [5:0] OP_ROL   = 6'b001110;
  localparam logic [5:0] OP_ROR   = 6'b001111;
  localparam logic [5:0] OP_LRSH  = 6'b010000;

  typedef enum logic {IDLE, WR_HI} state_t;
  typedef enum logic {SRC_ALU, SRC_LOAD} src_t;

  function automatic logic op_writes(input logic [5:0] op);
    return (op <= OP_MOV1) || ((op >= OP_ADD) && (op <= OP_LRSH));
  endfunction

endpackage

// File: rtl/wb_rr_arb.sv
// rtl/wb_rr_arb.sv - two-requester round-robin arbiter (ALU vs load return) holding the last grant.
import wb_pkg::*;

module wb_rr_arb (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic alu_valid,
  input  logic ld_valid,
  output logic alu_grant,
  output logic ld_grant
);

  src_t last;

  always_comb begin
    alu_grant = enable && alu_valid && (!ld_valid || (last == SRC_LOAD));
    ld_grant  = enable && ld_valid  && (!alu_valid || (last == SRC_ALU));
  end

  // Starting at LOAD lets the ALU win the first contest after reset.
  always_ff @(posedge clk) begin
    if (rst)
      last <= SRC_LOAD;
    else if (alu_grant)
      last <= SRC_ALU;
    else if (ld_grant)
      last <= SRC_LOAD;
  end

endmodule

// File: rtl/wb_controller.sv
// rtl/wb_controller.sv - register-file write-port scheduler; WB_MUL_HI_EN enables the MUL high-half second write.
import wb_pkg::*;

module wb_controller #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_valid,
  output logic                alu_ready,
  input  logic [5:0]          alu_op,
  input  logic [REG_AW-1:0]   alu_rd,
  input  logic [2*DATA_W-1:0] alu_result,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [REG_AW-1:0]   ld_rd,
  input  logic [DATA_W-1:0]   ld_data,
  output logic                rf_we,
  output logic [REG_AW-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic                busy,
  output logic                illegal_op
);

  state_t state;
  logic   enable;

  assign enable = (state == IDLE) && !rst;

  wb_rr_arb u_arb (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .alu_valid (alu_valid),
    .ld_valid  (ld_valid),
    .alu_grant (alu_ready),
    .ld_grant  (ld_ready)
  );

`ifdef WB_MUL_HI_EN
  logic [REG_AW-1:0] hi_addr;
  logic [DATA_W-1:0] hi_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      busy       <= 1'b0;
      illegal_op <= 1'b0;
      hi_addr    <= '0;
      hi_data    <= '0;
    end else begin
      rf_we      <= 1'b0;
      illegal_op <= 1'b0;
      busy       <= 1'b0;
      case (state)
        IDLE: begin
          if (alu_ready) begin
            if (op_writes(alu_op)) begin
              rf_we    <= 1'b1;
              rf_waddr <= alu_rd;
              rf_wdata <= alu_result[DATA_W-1:0];
            end
            illegal_op <= (alu_op > OP_LRSH);
            if (alu_op == OP_MUL) begin
              state   <= WR_HI;
              busy    <= 1'b1;
              hi_addr <= alu_rd + REG_AW'(1);
              hi_data <= alu_result[2*DATA_W-1:DATA_W];
            end
          end else if (ld_ready) begin
            rf_we    <= 1'b1;
            rf_waddr <= ld_rd;
            rf_wdata <= ld_data;
          end
        end
        WR_HI: begin
          rf_we    <= 1'b1;
          rf_waddr <= hi_addr;
          rf_wdata <= hi_data;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // Without the high-half sequence the product's upper bits have no destination.
  logic unused_hi;

  assign unused_hi = ^alu_result[2*DATA_W-1:DATA_W];
  assign state     = IDLE;
  assign busy      = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      illegal_op <= 1'b0;
    end else begin
      rf_we      <= 1'b0;
      illegal_op <= 1'b0;
      if (alu_ready) begin
        if (op_writes(alu_op)) begin
          rf_we    <= 1'b1;
          rf_waddr <= alu_rd;
          rf_wdata <= alu_result[DATA_W-1:0];
        end
        illegal_op <= (alu_op > OP_LRSH);
      end else if (ld_ready) begin
        rf_we    <= 1'b1;
        rf_waddr <= ld_rd;
        rf_wdata <= ld_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_controller.sv
// tb/tb_wb_controller.sv - directed bench with per-cycle reference model; honours WB_MUL_HI_EN.
module tb_wb_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [5:0]  alu_op = '0;
  logic [3:0]  alu_rd = '0;
  logic [31:0] alu_result = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [3:0]  ld_rd = '0;
  logic [15:0] ld_data = '0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        busy;
  logic        illegal_op;

  int checks = 0;
  int errors = 0;

  wb_controller #(.DATA_W(16), .REG_AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_op     (alu_op),
    .alu_rd     (alu_rd),
    .alu_result (alu_result),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy),
    .illegal_op (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expectations for the next cycle are derived from this cycle's inputs.
  bit          armed = 0;
  bit          m_last_ld = 1;
  bit          m_pend = 0;
  logic [3:0]  m_hi_addr;
  logic [15:0] m_hi_data;
  bit          e_we, e_ill, e_busy, e_zero;
  logic [3:0]  e_addr;
  logic [15:0] e_data;
  bit          m_alu_acc = 0, m_ld_acc = 0;

  always @(negedge clk) begin
    bit ar, lr;
    ar = !rst && !m_pend && alu_valid && (!ld_valid || m_last_ld);
    lr = !rst && !m_pend && ld_valid && (!alu_valid || !m_last_ld);
    if (armed) begin
      chk("alu_ready", alu_ready, ar);
      chk("ld_ready", ld_ready, lr);
      chk("rf_we", rf_we, e_we);
      chk("illegal_op", illegal_op, e_ill);
      chk("busy", busy, e_busy);
      if (e_we || e_zero) begin
        chk("rf_waddr", rf_waddr, e_addr);
        chk("rf_wdata", rf_wdata, e_data);
      end
    end
    m_alu_acc = ar;
    m_ld_acc  = lr;
    e_we = 0; e_ill = 0; e_busy = 0; e_zero = 0;
    if (rst) begin
      armed = 1; m_pend = 0; m_last_ld = 1;
      e_zero = 1; e_addr = 0; e_data = 0;
    end else if (m_pend) begin
      m_pend = 0;
      e_we = 1; e_addr = m_hi_addr; e_data = m_hi_data;
    end else if (ar) begin
      m_last_ld = 0;
      if (alu_op <= 1 || (alu_op >= 4 && alu_op <= 16)) begin
        e_we = 1; e_addr = alu_rd; e_data = alu_result[15:0];
      end
      if (alu_op >= 17) e_ill = 1;
`ifdef WB_MUL_HI_EN
      if (alu_op == 7) begin
        e_busy = 1; m_pend = 1;
        m_hi_addr = 4'((alu_rd + 1) % 16);
        m_hi_data = alu_result[31:16];
      end
`endif
    end else if (lr) begin
      m_last_ld = 1;
      e_we = 1; e_addr = ld_rd; e_data = ld_data;
    end
  end

  task automatic put(input logic r, input logic av, input logic [5:0] op, input logic [3:0] rd,
                     input logic [31:0] res, input logic lv, input logic [3:0] lrd, input logic [15:0] ld);
    rst = r; alu_valid = av; alu_op = op; alu_rd = rd; alu_result = res;
    ld_valid = lv; ld_rd = lrd; ld_data = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string name, input logic [3:0] a, input logic [15:0] d);
    chk({name, "_we"}, rf_we, 1'b1);
    chk({name, "_addr"}, rf_waddr, a);
    chk({name, "_data"}, rf_wdata, d);
  endtask

  logic [5:0] mix_ops [8] = '{6'd4, 6'd7, 6'd1, 6'd2, 6'd17, 6'd7, 6'd16, 6'd63};

  initial begin
    put(1, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("reset_we", rf_we, 0);
    chk("reset_addr", rf_waddr, 0);
    chk("reset_data", rf_wdata, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ill", illegal_op, 0);

    put(0, 1, 6'b000100, 4'd3, 32'h0000_1234, 0, 0, 0);
    #1 chk("add_ready", alu_ready, 1);
    tick();
    chk_wr("add", 4'd3, 16'h1234);

    put(0, 1, 6'b000111, 4'd15, 32'hABCD_5678, 0, 0, 0);
    tick();
    chk_wr("mul_lo", 4'd15, 16'h5678);
    put(0, 1, 6'b000100, 4'd5, 32'h0000_0055, 0, 0, 0);
`ifdef WB_MUL_HI_EN
    chk("mul_busy", busy, 1);
    #1 chk("mul_stall_ready", alu_ready, 0);
    tick();
    chk_wr("mul_hi", 4'd0, 16'hABCD);
    chk("mul_hi_busy", busy, 0);
    tick();
    chk_wr("add_after_mul", 4'd5, 16'h0055);
`else
    chk("mul_busy", busy, 0);
    #1 chk("mul_next_ready", alu_ready, 1);
    tick();
    chk_wr("add_after_mul", 4'd5, 16'h0055);
    put(0, 1, 6'b000111, 4'd4, 32'h0001_0002, 0, 0, 0);
    tick();
    chk_wr("mul_single", 4'd4, 16'h0002);
    put(0, 1, 6'b000100, 4'd6, 32'h0000_0066, 0, 0, 0);
    #1 chk("mul_single_ready", alu_ready, 1);
    tick();
    chk_wr("add_after_single", 4'd6, 16'h0066);
`endif

    put(0, 0, 0, 0, 0, 1, 4'd7, 16'h0777);
    tick();
    chk_wr("lone_load", 4'd7, 16'h0777);

    put(0, 1, 6'b000100, 4'd1, 32'h0000_0011, 1, 4'd2, 16'h00FF);
    tick(); chk_wr("rr0", 4'd1, 16'h0011);
    tick(); chk_wr("rr1", 4'd2, 16'h00FF);
    tick(); chk_wr("rr2", 4'd1, 16'h0011);
    tick(); chk_wr("rr3", 4'd2, 16'h00FF);

    put(0, 1, 6'b000011, 4'd8, 32'h0000_0BAD, 0, 0, 0);
    tick();
    chk("store_we", rf_we, 0);
    chk("store_ill", illegal_op, 0);
    put(0, 1, 6'b111111, 4'd8, 32'h0000_0BAD, 0, 0, 0);
    tick();
    chk("illegal_we", rf_we, 0);
    chk("illegal_pulse", illegal_op, 1);
    put(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("illegal_clear", illegal_op, 0);

    put(0, 1, 6'b000111, 4'd9, 32'h2222_3333, 0, 0, 0);
    tick();
    chk_wr("mulrst_lo", 4'd9, 16'h3333);
    put(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("mulrst_we", rf_we, 0);
    chk("mulrst_addr", rf_waddr, 0);
    chk("mulrst_data", rf_wdata, 0);
    chk("mulrst_busy", busy, 0);
    chk("mulrst_ill", illegal_op, 0);

    // Mixed contended traffic, each request held until the model accepts it.
    begin
      int ai = 0, li = 0;
      for (int c = 0; c < 40 && (ai < 8 || li < 6); c++) begin
        put(0, ai < 8, (ai < 8) ? mix_ops[ai] : 6'd0, 4'(ai * 2 + 1),
            {16'hA000 + 16'(ai), 16'h0100 + 16'(ai)},
            (li < 6) && (c >= 2), 4'(li + 8), 16'hC000 + 16'(li));
        tick();
        if (m_alu_acc) ai++;
        if (m_ld_acc) li++;
      end
      chk("mix_done", {ai[15:0], li[15:0]}, {16'd8, 16'd6});
    end

    put(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
